// File: rtl/spi_master.sv
// spi_master: single-byte SPI master with SCK idle low, MSB first, and one
// full-duplex 8-bit frame per CS assertion. SIMO changes on SCK rising and
// SOMI is captured on SCK falling.
module spi_master #(
  parameter int HALF_PERIOD = 8,
  parameter int CS_SETUP    = 8,
  parameter int CS_HOLD     = 8,
  parameter int CS_GAP      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       SCK,
  output logic       SIMO,
  output logic       CS,
  input  logic       SOMI
);

  // Terminal counts: a state whose length is N ends when cnt reaches N-1.
  localparam logic [15:0] HALF_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t      state;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [2:0]  bitcnt;
  logic [15:0] cnt;
  logic        somi_q;
  logic        somi_s;

  // Two-flop resynchroniser for the asynchronous SOMI line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      somi_q <= 1'b0;
      somi_s <= 1'b0;
    end else begin
      somi_q <= SOMI;
      somi_s <= somi_q;
    end
  end

  // Frame sequencer: drives CS/SCK/SIMO, shifts data, and reports completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_sh   <= 8'h00;
      rx_sh   <= 8'h00;
      bitcnt  <= 3'd0;
      cnt     <= 16'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= 8'h00;
      SCK     <= 1'b0;
      SIMO    <= 1'b0;
      CS      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          CS   <= 1'b1;
          SCK  <= 1'b0;
          SIMO <= 1'b0;
          if (start) begin
            tx_sh  <= tx_data;
            bitcnt <= 3'd0;
            cnt    <= 16'd0;
            CS     <= 1'b0;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= 16'd0;
            SCK   <= 1'b1;
            SIMO  <= tx_sh[7];
            tx_sh <= {tx_sh[6:0], 1'b0};
            state <= HIGH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        HIGH: begin
          if (cnt == HALF_LAST) begin
            cnt   <= 16'd0;
            SCK   <= 1'b0;
            rx_sh <= {rx_sh[6:0], somi_s};
            state <= LOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        LOW: begin
          if (cnt == HALF_LAST) begin
            cnt <= 16'd0;
            if (bitcnt == 3'd7) begin
              state <= HOLD;
            end else begin
              bitcnt <= bitcnt + 3'd1;
              SCK    <= 1'b1;
              SIMO   <= tx_sh[7];
              tx_sh  <= {tx_sh[6:0], 1'b0};
              state  <= HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= 16'd0;
            CS      <= 1'b1;
            SIMO    <= 1'b0;
            rx_data <= rx_sh;
            done    <= 1'b1;
            state   <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 16'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= 16'd0;
          busy  <= 1'b0;
          CS    <= 1'b1;
          SCK   <= 1'b0;
          SIMO  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed tests for spi_master. One instance uses the default
// timing parameters and a second uses minimal CS timing; a mux selects which
// instance the scenario tasks observe.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       use_b = 1'b0;
  int         somi_mode = 0;
  logic [7:0] slave_preload = 8'h00;

  logic       start_a, start_b, somi;
  logic       busy_a, done_a, sck_a, simo_a, cs_a;
  logic       busy_b, done_b, sck_b, simo_b, cs_b;
  logic [7:0] rx_a, rx_b;
  logic       busy_o, done_o, sck_o, simo_o, cs_o;
  logic [7:0] rx_data_o;

  logic [7:0] slave_sh = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  logic       slave_out = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign start_a = start & ~use_b;
  assign start_b = start & use_b;

  assign busy_o    = use_b ? busy_b : busy_a;
  assign done_o    = use_b ? done_b : done_a;
  assign sck_o     = use_b ? sck_b  : sck_a;
  assign simo_o    = use_b ? simo_b : simo_a;
  assign cs_o      = use_b ? cs_b   : cs_a;
  assign rx_data_o = use_b ? rx_b   : rx_a;

  // SOMI source: 0 loopback, 1 tied high, 2 tied low, 3 slave model
  assign somi = (somi_mode == 0) ? simo_o :
                (somi_mode == 1) ? 1'b1 :
                (somi_mode == 2) ? 1'b0 : slave_out;

  spi_master dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_data),
    .busy(busy_a), .done(done_a), .rx_data(rx_a),
    .SCK(sck_a), .SIMO(simo_a), .CS(cs_a), .SOMI(somi)
  );

  spi_master #(
    .HALF_PERIOD(8), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_data),
    .busy(busy_b), .done(done_b), .rx_data(rx_b),
    .SCK(sck_b), .SIMO(simo_b), .CS(cs_b), .SOMI(somi)
  );

  // 10-unit system clock
  always #5 clk = ~clk;

  // Edge counter used for timestamps
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: loads its byte on CS falling, drives MSB on each SCK rising
  always @(posedge sck_o or negedge cs_o) begin
    if (sck_o) begin
      slave_out <= slave_sh[7];
      slave_sh  <= {slave_sh[6:0], 1'b0};
    end else begin
      slave_sh <= slave_preload;
    end
  end

  // Slave model capture of SIMO on SCK falling
  always @(negedge sck_o) slave_rx <= {slave_rx[6:0], simo_o};

  // Runs one frame from a negedge, sampling every negedge until busy drops after done.
  task automatic run_frame(
    input  logic [7:0] tx,
    input  logic       next_start,
    input  logic [7:0] next_tx,
    output logic [7:0] rx,
    output logic [7:0] simo_bits,
    output int         rises,
    output int         cs_low,
    output int         done_cnt,
    output int         t_acc,
    output int         t_rise1,
    output int         t_done,
    output int         t_free,
    output int         cs_low_gap,
    output logic       timed_out
  );
    logic prev_sck;
    logic seen_done;
    start   = 1'b1;
    tx_data = tx;
    @(negedge clk);
    t_acc      = cyc;
    start      = next_start;
    tx_data    = next_tx;
    rx         = 8'h00;
    simo_bits  = 8'h00;
    rises      = 0;
    cs_low     = 0;
    done_cnt   = 0;
    t_rise1    = -1;
    t_done     = -1;
    t_free     = -1;
    cs_low_gap = 0;
    timed_out  = 1'b1;
    prev_sck   = 1'b0;
    seen_done  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!prev_sck && sck_o) begin
        rises++;
        if (t_rise1 < 0) t_rise1 = cyc;
      end
      if (prev_sck && !sck_o) simo_bits = {simo_bits[6:0], simo_o};
      prev_sck = sck_o;
      if (!cs_o) begin
        if (seen_done) cs_low_gap++;
        else cs_low++;
      end
      if (done_o) begin
        done_cnt++;
        if (!seen_done) begin
          t_done = cyc;
          rx     = rx_data_o;
        end
        seen_done = 1'b1;
      end
      if (seen_done && !busy_o) begin
        t_free    = cyc;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reset values while rst_n is held low
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs got=%b exp=1", cs_o); end
    checks++; if (sck_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_sck got=%b exp=0", sck_o); end
    checks++; if (simo_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_simo got=%b exp=0", simo_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (rx_data_o !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx got=%h exp=00", rx_data_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reset asserted in the 4th SCK high phase, then a clean 0x5A loopback frame
  task automatic test_reset_midframe;
    int rises;
    int dcount;
    int cslow;
    logic prev;
    logic [7:0] rx, sb;
    int r, cl, dc, ta, tr, td, tf, clg;
    logic to;
    rises = 0;
    dcount = 0;
    cslow = 0;
    prev = 1'b0;
    somi_mode = 0;
    start = 1'b1;
    tx_data = 8'hE7;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!prev && sck_o) rises++;
      prev = sck_o;
      if (rises == 4) break;
      @(negedge clk);
    end
    checks++; if (rises != 4) begin failures++; $display("[TB] FAIL mid_reach4 got=%0d exp=4", rises); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (cs_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_cs got=%b exp=1", cs_o); end
    checks++; if (sck_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_sck got=%b exp=0", sck_o); end
    checks++; if (simo_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_simo got=%b exp=0", simo_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_done got=%b exp=0", done_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_o) dcount++;
      if (!cs_o) cslow++;
    end
    checks++; if (dcount != 0) begin failures++; $display("[TB] FAIL mid_no_done got=%0d exp=0", dcount); end
    checks++; if (cslow != 0) begin failures++; $display("[TB] FAIL mid_cs_stays_high got=%0d exp=0", cslow); end
    checks++; if (rx_data_o !== 8'h00) begin failures++; $display("[TB] FAIL mid_rx got=%h exp=00", rx_data_o); end
    run_frame(8'h5A, 1'b0, 8'h00, rx, sb, r, cl, dc, ta, tr, td, tf, clg, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL mid_after_timeout got=1 exp=0"); end
    checks++; if (rx !== 8'h5A) begin failures++; $display("[TB] FAIL mid_after_rx got=%h exp=5a", rx); end
    checks++; if (dc != 1) begin failures++; $display("[TB] FAIL mid_after_done got=%0d exp=1", dc); end
  endtask

  // Loopback 0xA5 with default timing and exact frame timestamps
  task automatic test_loopback;
    logic [7:0] rx, sb;
    int r, cl, dc, ta, tr, td, tf, clg;
    logic to;
    somi_mode = 0;
    run_frame(8'hA5, 1'b0, 8'h5A, rx, sb, r, cl, dc, ta, tr, td, tf, clg, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL loop_timeout got=1 exp=0"); end
    checks++; if (rx !== 8'hA5) begin failures++; $display("[TB] FAIL loop_rx got=%h exp=a5", rx); end
    checks++; if (sb !== 8'hA5) begin failures++; $display("[TB] FAIL loop_simo got=%h exp=a5", sb); end
    checks++; if (r != 8) begin failures++; $display("[TB] FAIL loop_rises got=%0d exp=8", r); end
    checks++; if (cl != 144) begin failures++; $display("[TB] FAIL loop_cs_low got=%0d exp=144", cl); end
    checks++; if (tr - ta != 8) begin failures++; $display("[TB] FAIL loop_first_rise got=%0d exp=8", tr - ta); end
    checks++; if (td - ta != 144) begin failures++; $display("[TB] FAIL loop_done_time got=%0d exp=144", td - ta); end
    checks++; if (tf - td != 8) begin failures++; $display("[TB] FAIL loop_gap got=%0d exp=8", tf - td); end
    checks++; if (dc != 1) begin failures++; $display("[TB] FAIL loop_done_width got=%0d exp=1", dc); end
    checks++; if (rx_data_o !== 8'hA5) begin failures++; $display("[TB] FAIL loop_rx_hold got=%h exp=a5", rx_data_o); end
  endtask

  // Exchange with the slave model preloaded with 0x3C
  task automatic test_slave;
    logic [7:0] rx, sb;
    int r, cl, dc, ta, tr, td, tf, clg;
    logic to;
    somi_mode = 3;
    slave_preload = 8'h3C;
    run_frame(8'hC3, 1'b0, 8'h00, rx, sb, r, cl, dc, ta, tr, td, tf, clg, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL slave_timeout got=1 exp=0"); end
    checks++; if (slave_rx !== 8'hC3) begin failures++; $display("[TB] FAIL slave_captured got=%h exp=c3", slave_rx); end
    checks++; if (rx !== 8'h3C) begin failures++; $display("[TB] FAIL slave_master_rx got=%h exp=3c", rx); end
    checks++; if (dc != 1) begin failures++; $display("[TB] FAIL slave_done got=%0d exp=1", dc); end
  endtask

  // SOMI tied high then low while sending 0x81
  task automatic test_const_somi;
    logic [7:0] rx, sb;
    int r, cl, dc, ta, tr, td, tf, clg;
    logic to;
    somi_mode = 1;
    run_frame(8'h81, 1'b0, 8'h00, rx, sb, r, cl, dc, ta, tr, td, tf, clg, to);
    checks++; if (rx !== 8'hFF) begin failures++; $display("[TB] FAIL somi1_rx got=%h exp=ff", rx); end
    checks++; if (sb !== 8'h81) begin failures++; $display("[TB] FAIL somi1_simo got=%h exp=81", sb); end
    somi_mode = 2;
    run_frame(8'h81, 1'b0, 8'h00, rx, sb, r, cl, dc, ta, tr, td, tf, clg, to);
    checks++; if (rx !== 8'h00) begin failures++; $display("[TB] FAIL somi0_rx got=%h exp=00", rx); end
    checks++; if (sb !== 8'h81) begin failures++; $display("[TB] FAIL somi0_simo got=%h exp=81", sb); end
    checks++; if (to) begin failures++; $display("[TB] FAIL somi0_timeout got=1 exp=0"); end
  endtask

  // Pulsed 0x11, then start held with 0x22 through busy
  task automatic test_back_to_back;
    logic [7:0] rx1, sb1, rx2, sb2;
    int r1, cl1, dc1, ta1, tr1, td1, tf1, clg1;
    int r2, cl2, dc2, ta2, tr2, td2, tf2, clg2;
    logic to1, to2;
    somi_mode = 0;
    run_frame(8'h11, 1'b1, 8'h22, rx1, sb1, r1, cl1, dc1, ta1, tr1, td1, tf1, clg1, to1);
    run_frame(8'h22, 1'b0, 8'h00, rx2, sb2, r2, cl2, dc2, ta2, tr2, td2, tf2, clg2, to2);
    checks++; if (to1 || to2) begin failures++; $display("[TB] FAIL b2b_timeout got=%b%b exp=00", to1, to2); end
    checks++; if (sb1 !== 8'h11) begin failures++; $display("[TB] FAIL b2b_first_simo got=%h exp=11", sb1); end
    checks++; if (rx1 !== 8'h11) begin failures++; $display("[TB] FAIL b2b_first_rx got=%h exp=11", rx1); end
    checks++; if (dc1 != 1) begin failures++; $display("[TB] FAIL b2b_first_done got=%0d exp=1", dc1); end
    checks++; if (r1 != 8) begin failures++; $display("[TB] FAIL b2b_first_rises got=%0d exp=8", r1); end
    checks++; if (clg1 != 0) begin failures++; $display("[TB] FAIL b2b_cs_glitch got=%0d exp=0", clg1); end
    checks++; if (ta2 - tf1 != 1) begin failures++; $display("[TB] FAIL b2b_accept_after_free got=%0d exp=1", ta2 - tf1); end
    checks++; if (ta2 - td1 != 9) begin failures++; $display("[TB] FAIL b2b_cs_high_cycles got=%0d exp=9", ta2 - td1); end
    checks++; if (sb2 !== 8'h22) begin failures++; $display("[TB] FAIL b2b_second_simo got=%h exp=22", sb2); end
    checks++; if (rx2 !== 8'h22) begin failures++; $display("[TB] FAIL b2b_second_rx got=%h exp=22", rx2); end
  endtask

  // Minimal CS timing on the second instance
  task automatic test_fast_timing;
    logic [7:0] rx, sb;
    int r, cl, dc, ta, tr, td, tf, clg;
    logic to;
    somi_mode = 0;
    use_b = 1'b1;
    @(negedge clk);
    run_frame(8'h96, 1'b0, 8'h69, rx, sb, r, cl, dc, ta, tr, td, tf, clg, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL fast_timeout got=1 exp=0"); end
    checks++; if (tr - ta != 1) begin failures++; $display("[TB] FAIL fast_first_rise got=%0d exp=1", tr - ta); end
    checks++; if (td - ta != 130) begin failures++; $display("[TB] FAIL fast_done_time got=%0d exp=130", td - ta); end
    checks++; if (cl != 130) begin failures++; $display("[TB] FAIL fast_cs_low got=%0d exp=130", cl); end
    checks++; if (tf - td != 1) begin failures++; $display("[TB] FAIL fast_gap got=%0d exp=1", tf - td); end
    checks++; if (rx !== 8'h96) begin failures++; $display("[TB] FAIL fast_rx got=%h exp=96", rx); end
    checks++; if (r != 8) begin failures++; $display("[TB] FAIL fast_rises got=%0d exp=8", r); end
    checks++; if (dc != 1) begin failures++; $display("[TB] FAIL fast_done_width got=%0d exp=1", dc); end
    use_b = 1'b0;
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset;
    test_reset_midframe;
    test_loopback;
    test_slave;
    test_const_somi;
    test_back_to_back;
    test_fast_timing;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-byte SPI master driving SCK/SIMO/CS toward an SPI slave and capturing SOMI, for the WacBoard FPGA EPP/SPI path. A local client requests a transfer with `start`/`tx_data`. The block runs one full-duplex 8-bit frame per CS assertion, MSB first, SCK idle low. SIMO changes on SCK rising and is sampled by the slave on SCK falling, which matches the on-board slave (one byte per CS frame, SCK oversampled through a 3-flop synchroniser).

## Interface
Parameters:
- `HALF_PERIOD`, 8: clk cycles per SCK half period; legal 8..65535. The minimum covers slave SCK sync plus the SOMI resync here.
- `CS_SETUP`, 8: clk cycles from CS falling to first SCK rising; legal 1..65535.
- `CS_HOLD`, 8: clk cycles from last SCK falling to CS rising; legal 1..65535.
- `CS_GAP`, 8: minimum clk cycles CS stays high before the next frame; legal 1..65535.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  transfer request; sampled only when `busy`=0.
- `tx_data`  in  8  byte to send; latched on the accepted `start`.
- `busy`  out  1  high from the cycle after acceptance until GAP ends.
- `done`  out  1  one-cycle pulse; `rx_data` valid from this cycle on.
- `rx_data`  out  8  last received byte; holds until the next `done`.
- `SCK`  out  1  SPI clock, idle low.
- `SIMO`  out  1  master data out.
- `CS`  out  1  chip select, active low.
- `SOMI`  in  1  slave data in; 2-flop synchronised internally (`somi_s`).

## Operation
- Registers: `tx_sh[7:0]`, `rx_sh[7:0]`, `bitcnt[2:0]`, `cnt[15:0]`, state.
- IDLE: CS=1, SCK=0, SIMO=0. On `start`=1, load `tx_sh`<=`tx_data`, `bitcnt`<=0, `cnt`<=0, CS<=0, `busy`<=1, go to SETUP.
- SETUP: count `CS_SETUP` cycles. Then SCK<=1, SIMO<=`tx_sh[7]`, `tx_sh`<=`tx_sh`<<1, go to HIGH.
- HIGH: count `HALF_PERIOD` cycles. Then SCK<=0, `rx_sh`<={`rx_sh[6:0]`,`somi_s`}, go to LOW.
- LOW: count `HALF_PERIOD` cycles.
  - If `bitcnt`=7, go to HOLD.
  - Otherwise `bitcnt`++, SCK<=1, SIMO<=`tx_sh[7]`, shift `tx_sh`, go to HIGH.
- HOLD: count `CS_HOLD` cycles. Then CS<=1, SIMO<=0, `rx_data`<=`rx_sh`, `done`<=1, go to GAP.
- GAP: count `CS_GAP` cycles. Then `busy`<=0, go to IDLE.
- `cnt` clears on every state transition. A state with parameter N lasts exactly N cycles.
- `start` while `busy`=1 is ignored and not queued. `tx_data` changes after acceptance have no effect.
- Exactly 8 SCK rising edges per frame. SIMO changes only in the same cycle as SCK rising, so it is stable through every SCK falling edge.

## Timing
- Reset (`rst_n`=0 at a clk edge) gives CS=1, SCK=0, SIMO=0, `busy`=0, `done`=0, `rx_data`=0x00, state IDLE, all shift registers and counters 0.
- Reset mid-frame: same values on the next edge. CS rises immediately, no `done` is issued, and the partial byte is discarded.
- Acceptance at edge t: CS low and `busy` high from edge t. First SCK rising at t+`CS_SETUP`.
- SCK high and low phases are exactly `HALF_PERIOD` cycles each.
- CS rises and `done` pulses at t+`CS_SETUP`+16·`HALF_PERIOD`+`CS_HOLD`. `done` is high for exactly 1 cycle.
- `busy` falls `CS_GAP` cycles after `done`. The earliest next acceptance is the edge where `busy` is sampled 0.
- With defaults, a frame is 8+128+8 = 144 cycles CS low, plus 8 cycles of gap.
- SOMI is sampled 2 cycles stale via `somi_s`. A legal `HALF_PERIOD` guarantees the slave's post-rising-edge update has settled.

## Test plan
- Loopback (SOMI tied to SIMO), `tx_data`=0xA5, defaults: `rx_data`=0xA5 at `done`; 8 SCK rising edges; CS low for 144 cycles.
- Against slave model preloaded with 0x3C, master sends 0xC3: slave captures 0xC3, master `rx_data`=0x3C, `done` pulses once.
- SOMI tied 1 then tied 0: `rx_data`=0xFF, then 0x00. SIMO reproduces `tx_data`=0x81 MSB first, checked at each SCK falling edge.
- `start` pulsed with `tx_data`=0x11, then `start` held high with `tx_data`=0x22 throughout `busy`: the first frame sends 0x11; the second frame sends 0x22 and begins only after `busy` falls; no CS glitch in between.
- `rst_n` asserted during the 4th SCK high phase: the next cycle shows CS=1, SCK=0, SIMO=0, `busy`=0, no `done`, `rx_data` unchanged at 0x00. A new 0x5A loopback frame then completes correctly.
- `HALF_PERIOD`=8, `CS_SETUP`=1, `CS_HOLD`=1, `CS_GAP`=1: exact edge timestamps match the formula, and the frame is 130 cycles CS low.
